// File: rtl/uart_tx.sv
// uart_tx: 8-bit asynchronous serial transmitter.
//   Frame: start bit (0), data[0]..data[7] LSB first, optional even parity,
//   stop bit (1); every bit lasts CLKS_PER_BIT clock cycles.
//   Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit).
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   tx_en  in   transmitter enable; low aborts/holds the line idle
//   start  in   send request (pulse or level), accepted only when idle
//   data   in   byte to send, captured on the accept cycle
//   TX     out  registered serial line, idle high
//   busy   out  high while a frame is in progress
//   done   out  one-cycle pulse in the first idle cycle after the stop bit
module uart_tx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       start,
  input  logic [7:0] data,
  output logic       TX,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    if (!tx_en) begin
      state_d = IDLE;
      baud_d  = '0;
      bit_d   = '0;
      tx_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_d = '0;
          tx_d   = 1'b1;
          if (start) begin
            shift_d = data;
            bit_d   = '0;
            tx_d    = 1'b0;
            state_d = START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_d    = shift_q[0];
            state_d = DATA;
          end
        end
        DATA: begin
          // The register rotates rather than shifts so that its XOR stays
          // equal to the original byte's parity for the whole frame.
          if (bit_end) begin
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_d    = ^shift_q;
              state_d = PARITY;
`else
              tx_d    = 1'b1;
              state_d = STOP;
`endif
            end else begin
              bit_d   = bit_q + 3'd1;
              shift_d = {shift_q[0], shift_q[7:1]};
              tx_d    = shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            tx_d    = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  assign TX   = tx_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with CLKS_PER_BIT = 16.
// The reference model builds the expected line value for any cycle offset
// from the accept edge directly from the frame format.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       TX, busy, done;

  int errors = 0;
  int checks = 0;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .start(start),
    .data(data), .TX(TX), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit i of the frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic check_out(input string name, input int k,
                           input logic etx, input logic ebusy, input logic edone);
    checks++;
    if ({TX, busy, done} !== {etx, ebusy, edone}) begin
      errors++;
      $display("FAIL %s k=%0d: TX/busy/done got %b%b%b expected %b%b%b",
               name, k, TX, busy, done, etx, ebusy, edone);
    end
  endtask

  // Called right before the accept edge; checks one whole frame plus the
  // done cycle and one more idle cycle. With noise, data and start are
  // scrambled while busy and must have no effect.
  task automatic frame_check(input string name, input logic [7:0] b, input bit noise);
    for (int k = 1; k <= FC + 2; k++) begin
      step();
      if (k <= FC) check_out(name, k, frame_bit(b, (k - 1) / CPB), 1'b1, 1'b0);
      else         check_out(name, k, 1'b1, 1'b0, k == FC + 1);
      start = (noise && k < FC) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (noise) data = 8'($urandom);
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] b, input bit noise);
    start = 1'b1;
    data  = b;
    frame_check(name, b, noise);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tx_en = 1'b1;
    start = 1'b1;
    data  = 8'h96;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k > 0) check_out("reset_hold", k, 1'b1, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    frame_check("first_accept", 8'h96, 1'b0);
  endtask

  task automatic test_frames();
    run_frame("frame_a5", 8'hA5, 1'b0);
    run_frame("ignore_12", 8'h12, 1'b1);
    for (int n = 0; n < 6; n++) run_frame("random", 8'($urandom), 1'b1);
    run_frame("frame_00", 8'h00, 1'b0);
    run_frame("frame_ff", 8'hFF, 1'b0);
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    data  = 8'h3C;
    for (int k = 1; k <= 2 * FC + 10; k++) begin
      step();
      if (k <= FC)
        check_out("b2b", k, frame_bit(8'h3C, (k - 1) / CPB), 1'b1, 1'b0);
      else if (k == FC + 1)
        check_out("b2b", k, 1'b1, 1'b0, 1'b1);
      else if (k <= 2 * FC + 1)
        check_out("b2b", k, frame_bit(8'hC3, (k - FC - 2) / CPB), 1'b1, 1'b0);
      else
        check_out("b2b", k, 1'b1, 1'b0, k == 2 * FC + 2);
      data = 8'hC3;
      if (k >= FC + 10) start = 1'b0;
    end
  endtask

  task automatic test_abort();
    logic [7:0] b = 8'($urandom);
    start = 1'b1;
    data  = b;
    for (int k = 1; k <= FC + 10; k++) begin
      step();
      start = 1'b0;
      if (k <= 50) check_out("abort", k, frame_bit(b, (k - 1) / CPB), 1'b1, 1'b0);
      else         check_out("abort", k, 1'b1, 1'b0, 1'b0);
      if (k == 50) tx_en = 1'b0;
    end
    tx_en = 1'b1;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b = 8'($urandom);
    start = 1'b1;
    data  = b;
    for (int k = 1; k <= FC + 10; k++) begin
      step();
      start = 1'b0;
      if (k <= 80) check_out("rst_mid", k, frame_bit(b, (k - 1) / CPB), 1'b1, 1'b0);
      else         check_out("rst_mid", k, 1'b1, 1'b0, 1'b0);
      rst_n = (k == 80) ? 1'b0 : 1'b1;
      if (k == 80) start = 1'b1;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_disabled_start();
    tx_en = 1'b0;
    start = 1'b1;
    data  = 8'h5A;
    for (int k = 1; k <= 40; k++) begin
      step();
      check_out("en_off", k, 1'b1, 1'b0, 1'b0);
    end
    start = 1'b0;
    tx_en = 1'b1;
    step();
    check_out("en_off_after", 41, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    test_disabled_start();
    run_frame("after_all", 8'h6D, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
